vga_scan_ctrl: RTL and testbench

Scan controller that sequences the pixel-source ROM. It generates the horizontal/vertical pixel addresses that the ROM decodes, registers the returned colour, and produces matching VGA sync and blank signals. It sits between the combinational pixel source and the DAC/video pins, and starts and stops scanning on frame boundaries under an enable.

---
 rtl/vga_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: scan controller for a combinational pixel-source ROM.
// Generates horizontal/vertical pixel addresses, registers the returned
// colour and produces aligned VGA sync, blank and frame-start outputs.
// Scanning starts and stops only on frame boundaries under iEn.
//
// Ports:
//   iClk, iRst_n            pixel clock, asynchronous active-low reset
//   iEn                     scan enable
//   oHAddr, oVAddr          pixel address (raw counters, porches included)
//   iRed, iGreen, iBlue     colour from the pixel source for oHAddr/oVAddr
//   oVgaR, oVgaG, oVgaB     registered colour, zero outside the visible area
//   oHsync, oVsync          registered syncs, active level SYNC_POL
//   oBlank_n                registered, high in the visible region
//   oFrameStart             one-cycle pulse aligned with output pixel (0,0)
//   oFrameCnt               (SCAN_FRAME_CNT_EN only) 16-bit wrapping count
//                           of frame-start pulses
//
// Optional feature macro: SCAN_FRAME_CNT_EN.
module vga_scan_ctrl #(
  parameter int unsigned addrWidth = 11,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter logic        SYNC_POL  = 1'b1
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEn,
  output logic [addrWidth-1:0] oHAddr,
  output logic [addrWidth-1:0] oVAddr,
  input  logic [7:0]           iRed,
  input  logic [7:0]           iGreen,
  input  logic [7:0]           iBlue,
  output logic [7:0]           oVgaR,
  output logic [7:0]           oVgaG,
  output logic [7:0]           oVgaB,
  output logic                 oHsync,
  output logic                 oVsync,
  output logic                 oBlank_n,
  output logic                 oFrameStart
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]          oFrameCnt
`endif
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 en_q;
  logic [addrWidth-1:0] h_cnt_q, h_cnt_d;
  logic [addrWidth-1:0] v_cnt_q, v_cnt_d;

  logic [7:0] vga_r_q, vga_r_d;
  logic [7:0] vga_g_q, vga_g_d;
  logic [7:0] vga_b_q, vga_b_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic       frame_start_q, frame_start_d;

  logic scanning;
  logic h_last;
  logic v_last;
  logic visible;
  logic h_in_sync;
  logic v_in_sync;

  // Position decode from the current counters
  always_comb begin
    scanning  = (state_q != ST_IDLE);
    h_last    = (h_cnt_q == addrWidth'(H_TOTAL - 1));
    v_last    = (v_cnt_q == addrWidth'(V_TOTAL - 1));
    visible   = (h_cnt_q < addrWidth'(H_ACTIVE)) && (v_cnt_q < addrWidth'(V_ACTIVE));
    h_in_sync = (h_cnt_q >= addrWidth'(H_SYNC_START)) && (h_cnt_q <= addrWidth'(H_SYNC_END));
    v_in_sync = (v_cnt_q >= addrWidth'(V_SYNC_START)) && (v_cnt_q <= addrWidth'(V_SYNC_END));
  end

  // Next state, counters and output-stage inputs
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vga_r_d       = 8'd0;
    vga_g_d       = 8'd0;
    vga_b_d       = 8'd0;
    hsync_d       = !SYNC_POL;
    vsync_d       = !SYNC_POL;
    blank_n_d     = 1'b0;
    frame_start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_q) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        // Re-enable wins over the end-of-frame stop so there is no gap
        if (en_q)                 state_d = ST_RUN;
        else if (h_last && v_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (scanning) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + addrWidth'(1);
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + addrWidth'(1);

      if (visible) begin
        vga_r_d = iRed;
        vga_g_d = iGreen;
        vga_b_d = iBlue;
      end
      hsync_d       = h_in_sync ? SYNC_POL : !SYNC_POL;
      vsync_d       = v_in_sync ? SYNC_POL : !SYNC_POL;
      blank_n_d     = visible;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  // iEn is sampled into a flop ahead of the FSM, so a scan begins two edges
  // after iEn is first seen and the first frame-start pulse follows one later
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      en_q    <= iEn;
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Output stage: one register for colour, syncs, blank and frame start
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vga_r_q       <= 8'd0;
      vga_g_q       <= 8'd0;
      vga_b_q       <= 8'd0;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises oFrameStart, so it reads 1 in frame 1
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) frame_cnt_q <= 16'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign oFrameCnt = frame_cnt_q;
`endif

  assign oHAddr      = h_cnt_q;
  assign oVAddr      = v_cnt_q;
  assign oVgaR       = vga_r_q;
  assign oVgaG       = vga_g_q;
  assign oVgaB       = vga_b_q;
  assign oHsync      = hsync_q;
  assign oVsync      = vsync_q;
  assign oBlank_n    = blank_n_q;
  assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: self-checking bench for vga_scan_ctrl using a reduced
// raster so several full frames fit in a short run. A reference model
// tracks the frame position linearly and pushes the expected registered
// outputs to a scoreboard queue at each clock edge.
module tb_vga_scan_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned HA = 8;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 3;
  localparam int unsigned HB = 2;
  localparam int unsigned VA = 6;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic POL = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] h_addr, v_addr;
  logic [7:0]    red, green, blue;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          hsync, vsync, blank_n, frame_start;
`ifdef SCAN_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .addrWidth(AW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .iClk(clk), .iRst_n(rst_n), .iEn(en),
    .oHAddr(h_addr), .oVAddr(v_addr),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oVgaR(vga_r), .oVgaG(vga_g), .oVgaB(vga_b),
    .oHsync(hsync), .oVsync(vsync), .oBlank_n(blank_n),
    .oFrameStart(frame_start)
`ifdef SCAN_FRAME_CNT_EN
    , .oFrameCnt(frame_cnt)
`endif
  );

  // Pixel source: constant colour or an address-dependent pattern
  logic const_mode;
  always_comb begin
    if (const_mode) begin
      red   = 8'hDA;
      green = 8'hD7;
      blue  = 8'hC0;
    end else begin
      red   = 8'(32'(h_addr) * 7 + 1);
      green = 8'(32'(v_addr) * 13 + 3);
      blue  = 8'(32'(h_addr ^ v_addr));
    end
  end

  function automatic logic [23:0] pix(input int h, input int v);
    if (const_mode) return 24'hDAD7C0;
    return {8'(h * 7 + 1), 8'(v * 13 + 3), 8'(h ^ v)};
  endfunction

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } out_t;

  out_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_state;   // 0 idle, 1 run, 2 stopping
  int   m_pos;     // linear position in frame of the counters
  int   m_fcnt;
  logic m_en_q;
  int   edge_n;

  logic meas;
  int   hs_n, vs_n, bl_n;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pos   = 0;
    m_fcnt  = 0;
    m_en_q  = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive iEn, predict the registered outputs, compare after edge
  task automatic step(input logic en_val);
    out_t e;
    out_t a;
    int   h, v, nxt;
    logic scan, act;
    en = en_val;
    @(posedge clk);
    edge_n++;
    h    = m_pos % HT;
    v    = m_pos / HT;
    scan = (m_state != 0);
    act  = scan && (h < HA) && (v < VA);
    {e.r, e.g, e.b} = act ? pix(h, v) : 24'h0;
    e.hs = (scan && h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    e.vs = (scan && v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
    e.bl = act;
    e.fs = scan && (m_pos == 0);
    if (e.fs) m_fcnt = (m_fcnt + 1) % 65536;
    sb_q.push_back(e);
    nxt = m_state;
    case (m_state)
      0: if (m_en_q) nxt = 1;
      1: if (!m_en_q) nxt = 2;
      default: begin
        if (m_en_q) nxt = 1;
        else if (m_pos == FRAME - 1) nxt = 0;
      end
    endcase
    if (scan) m_pos = (m_pos + 1) % FRAME;
    m_state = nxt;
    m_en_q  = en_val;
    #1;
    a = {vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start};
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(a), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check_val("outputs", 32'(a), 32'(e));
    end
    check_val("haddr", 32'(h_addr), 32'(m_pos % HT));
    check_val("vaddr", 32'(v_addr), 32'(m_pos / HT));
`ifdef SCAN_FRAME_CNT_EN
    check_val("fcnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
    if (meas) begin
      hs_n += int'(hsync);
      vs_n += int'(vsync);
      bl_n += int'(blank_n);
    end
  endtask

  task automatic wait_fs(input int budget, output int n);
    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (!frame_start && n < budget);
    if (!frame_start) check_val("fs_timeout", 32'(frame_start), 32'd1);
  endtask

  task automatic run_to(input int pos, input logic en_val);
    int n = 0;
    do begin
      step(en_val);
      n++;
    end while (m_pos != pos && n < 2 * FRAME);
    check_val("run_to_pos", 32'(h_addr + v_addr * HT), 32'(pos));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'd0);
    check_val({tag, "_syncs"}, 32'({hsync, vsync}), 32'({~POL, ~POL}));
    check_val({tag, "_blank"}, 32'(blank_n), 32'd0);
    check_val({tag, "_fs"},    32'(frame_start), 32'd0);
    check_val({tag, "_addr"},  32'({h_addr, v_addr}), 32'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    en         = 1'b0;
    const_mode = 1'b1;
    meas       = 1'b0;
    hs_n = 0; vs_n = 0; bl_n = 0;
    edge_n = 0;
    model_reset();

    // Power-on reset, then idle with iEn low
    #12;
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (100) step(1'b0);
    check_reset_vals("idle100");

    // Enable with constant colour: first frame-start two edges after sampling
    n = edge_n + 1;
    wait_fs(10, hs_n);
    check_val("fs_latency", 32'(edge_n - n), 32'd2);

    // Measure one full frame of syncs and blank
    hs_n = int'(hsync);
    vs_n = int'(vsync);
    bl_n = int'(blank_n);
    meas = 1'b1;
    repeat (FRAME - 1) step(1'b1);
    meas = 1'b0;
    check_val("hsync_clks", 32'(hs_n), 32'(HS * VT));
    check_val("vsync_clks", 32'(vs_n), 32'(VS * HT));
    check_val("blank_clks", 32'(bl_n), 32'(HA * VA));
    wait_fs(FRAME + 5, n);
    check_val("fs_period", 32'(n), 32'd1);

    // Pattern source; drop iEn at line 3 and re-raise at line 7: no gap
    const_mode = 1'b0;
    run_to(3 * HT, 1'b1);
    run_to(7 * HT + 5, 1'b0);
    run_to(0, 1'b1);
    run_to(3 * HT, 1'b1);

    // Drop iEn for good: frame completes, then counters park at (0,0)
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (m_state != 0 && n < 2 * FRAME);
    repeat (20) step(1'b0);
    check_reset_vals("stopped");

    // Restart, then assert reset mid-frame at line 2 pixel 4
    wait_fs(10, n);
    run_to(2 * HT + 4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    wait_fs(10, n);
    check_val("rst_restart", 32'(n), 32'd3);
`ifdef SCAN_FRAME_CNT_EN
    check_val("fcnt_1", 32'(frame_cnt), 32'd1);
`endif
    wait_fs(FRAME + 5, n);
    check_val("fs_period2", 32'(n), 32'(FRAME));
`ifdef SCAN_FRAME_CNT_EN
    check_val("fcnt_2", 32'(frame_cnt), 32'd2);
`endif
    wait_fs(FRAME + 5, n);
`ifdef SCAN_FRAME_CNT_EN
    check_val("fcnt_3", 32'(frame_cnt), 32'd3);
`endif
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
